matrix_slot_allocator: RTL and testbench
========================================

Name: matrix_slot_allocator

Overview:
- Storage stage directly downstream of the UART input subsystem: receives dimension requests (m, n), allocates a fixed-size matrix slot, returns its base address, and absorbs the element write stream into an internal RAM.
- Commits completed matrices into a slot table and exposes a read port (slot, index) for compute and display stages.
- Enforces a per-dimension matrix limit with oldest-first replacement.

Parameters:
- NUM_SLOTS, 8, number of matrix slots. Constraint: NUM_SLOTS*SLOT_WORDS <= 256.
- SLOT_WORDS, 25, words reserved per slot (5x5 max).
- MAX_PER_DIM, 2, maximum valid matrices sharing one (m, n).
- DATA_W, 4, stored bits per element (low bits of the write data).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- w_en_input  in  1  input subsystem enable. Low aborts any pending allocation.
- w_dims_valid  in  1  dimension request, level, held high while the requester waits
- w_dim_m  in  32  requested rows
- w_dim_n  in  32  requested columns
- w_input_we  in  1  element write strobe
- w_real_addr  in  8  absolute write address
- w_input_data  in  32  element value. Bits [DATA_W-1:0] are stored.
- w_rx_done  in  1  input-complete pulse
- w_base_addr  out  8  granted slot base = slot*SLOT_WORDS
- w_addr_ready  out  1  one-cycle grant pulse
- w_alloc_err  out  1  one-cycle pulse: dimension out of range
- w_wr_drop  out  1  one-cycle pulse: write rejected
- w_slot_valid  out  NUM_SLOTS  committed-slot bitmap
- w_cur_slot  out  3  slot index of the last grant
- w_rd_slot  in  3  read slot select
- w_rd_idx  in  5  element index within slot
- w_rd_data  out  DATA_W  read data, 1-cycle latency
- w_rd_m  out  3  dims of w_rd_slot, combinational
- w_rd_n  out  3  dims of w_rd_slot, combinational

Behaviour:
- Reset (async):
  - FSM goes to IDLE.
  - w_base_addr, w_cur_slot, w_rd_data = 0; all pulses = 0; w_slot_valid = 0.
  - Slot table (m, n, seq) cleared; 8-bit sequence counter seq_ctr = 0; pending flag cleared.
  - RAM contents are not reset and are don't-care until written.
- FSM states: IDLE, SCAN, GRANT, FILL.
- IDLE:
  - On w_dims_valid=1, latch m, n (low 3 bits, after a full 32-bit range check 1..5).
  - Out of range: pulse w_alloc_err next cycle and stay in IDLE.
  - In range: go to SCAN.
- SCAN:
  - One slot examined per cycle, NUM_SLOTS cycles.
  - Tracks: lowest-index free slot; count of valid slots matching (m, n); oldest matching slot; oldest valid slot overall.
  - Age of a slot is seq_ctr - slot_seq (mod 256); largest age is oldest.
- GRANT victim selection, in priority order:
  - If the matching count >= MAX_PER_DIM, take the oldest matching slot.
  - Else if a free slot exists, take the lowest free slot.
  - Else take the oldest valid slot.
- GRANT actions:
  - Clear the victim's valid bit.
  - Write m, n and seq=seq_ctr into the victim's table entry; increment seq_ctr.
  - Drive w_base_addr and w_cur_slot; pulse w_addr_ready for exactly one cycle; set pending; go to FILL.
- Grant latency: w_addr_ready is high in cycle NUM_SLOTS+2, counting the cycle in which IDLE samples w_dims_valid as cycle 0.
- w_base_addr holds stable until the next grant.
- FILL write rule:
  - A write is accepted into RAM at w_real_addr when w_input_we=1 and base <= addr < base + m*n.
  - Any write outside that window, or any write outside FILL, is dropped with a w_wr_drop pulse.
  - Repeated writes to the same address overwrite (pre-clear followed by data is legal).
- FILL transitions:
  - w_rx_done=1: commit (set the valid bit), clear pending, go to IDLE.
  - Rearm: after the grant, w_dims_valid must be sampled low at least once before a new request is honoured. A lingering high level never re-triggers.
  - Rearmed and w_dims_valid=1: commit the pending slot, latch the new dims (range check as in IDLE), go to SCAN. This is the path for generating a second matrix.
  - w_rx_done and a rearmed request in the same cycle: w_rx_done wins; the request is then served from IDLE.
- w_en_input=0 in any state:
  - Go to IDLE and discard pending; the victim slot stays invalid and its old contents are lost.
  - Committed slots are retained.
- Read port:
  - RAM address = w_rd_slot*SLOT_WORDS + w_rd_idx.
  - w_rd_data is registered (1-cycle latency).
  - A read and a write to the same address in the same cycle returns the old data.
  - w_rd_slot >= NUM_SLOTS returns 0, with w_rd_m = w_rd_n = 0.
- Arithmetic: m*n is at most 25 (5 bits); base + m*n is computed in 9 bits, so there is no wrap.

Test Plan:
- Request 2x3, then 6 writes of 1..6 at base+0..5, then w_rx_done. Expect:
  - base = 0 and w_addr_ready exactly 10 cycles after the request.
  - w_slot_valid = 8'h01; reading slot 0, idx 0..5 returns 1..6 one cycle later; w_rd_m = 2, w_rd_n = 3.
- Request 3x3 and commit it three times → slots 0 and 1 are filled, and the third grant reuses slot 0 (the oldest match), whose valid bit is cleared during FILL.
- w_dim_m = 7 → w_alloc_err pulse, no w_addr_ready, FSM stays in IDLE. Then a valid 1x1 request is granted normally.
- w_dims_valid held high for 5 cycles after a grant → exactly one w_addr_ready. Drop it low, then raise it → the first slot commits and a second grant lands at base 25.
- Write to base + m*n during FILL → w_wr_drop pulse, RAM at that address unchanged.
- Drop w_en_input mid-FILL, or assert rst_n low mid-SCAN → no commit, the slot stays invalid, FSM is in IDLE. After reset, w_slot_valid = 0.

Source files
------------

// File: rtl/matrix_slot_allocator.sv
// matrix_slot_allocator
// Storage stage behind the UART input subsystem. A dimension request (m, n)
// is range checked, then an 8-cycle scan of the slot table picks a victim
// slot (oldest same-shape matrix when the per-shape limit is reached, else
// the lowest free slot, else the oldest matrix overall). The element stream
// is then absorbed into the shared RAM inside the granted window, and the
// slot is committed on w_rx_done or when a fresh request arrives.
//
// Request handshake: w_dims_valid is a level that the requester holds high
// while it waits. A request is taken only when the block is "armed", i.e.
// w_dims_valid has been seen low at least once since the previous grant or
// range error. The grant is the one-cycle w_addr_ready pulse, with
// w_base_addr/w_cur_slot valid in that cycle and held until the next grant.
module matrix_slot_allocator #(
    parameter int NUM_SLOTS   = 8,
    parameter int SLOT_WORDS  = 25,
    parameter int MAX_PER_DIM = 2,
    parameter int DATA_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 w_en_input,
    input  logic                 w_dims_valid,
    input  logic [31:0]          w_dim_m,
    input  logic [31:0]          w_dim_n,
    input  logic                 w_input_we,
    input  logic [7:0]           w_real_addr,
    input  logic [31:0]          w_input_data,
    input  logic                 w_rx_done,
    output logic [7:0]           w_base_addr,
    output logic                 w_addr_ready,
    output logic                 w_alloc_err,
    output logic                 w_wr_drop,
    output logic [NUM_SLOTS-1:0] w_slot_valid,
    output logic [2:0]           w_cur_slot,
    input  logic [2:0]           w_rd_slot,
    input  logic [4:0]           w_rd_idx,
    output logic [DATA_W-1:0]    w_rd_data,
    output logic [2:0]           w_rd_m,
    output logic [2:0]           w_rd_n,
    output logic [1:0]           fsm_state
);

    localparam int DEPTH = NUM_SLOTS * SLOT_WORDS;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;
    localparam logic [1:0] ST_FILL  = 2'd3;

    logic [1:0]        state;
    logic              armed;
    logic              pending;
    logic [2:0]        cur_m;
    logic [2:0]        cur_n;
    logic [7:0]        seq_ctr;
    logic [8:0]        fill_end;

    // slot table
    logic [2:0]        tbl_m   [NUM_SLOTS];
    logic [2:0]        tbl_n   [NUM_SLOTS];
    logic [7:0]        tbl_seq [NUM_SLOTS];

    // scan trackers
    logic [2:0]        scan_idx;
    logic              free_found;
    logic [2:0]        free_slot;
    logic [3:0]        match_cnt;
    logic [2:0]        match_slot;
    logic [7:0]        match_age;
    logic              all_found;
    logic [2:0]        all_slot;
    logic [7:0]        all_age;

    // element storage (not reset)
    logic [DATA_W-1:0] mem [DEPTH];

    // combinational helpers
    logic              dims_ok;
    logic              req_take;
    logic              req_window;
    logic              start_scan;
    logic              req_err;
    logic              do_grant;
    logic              do_commit;
    logic              scan_valid;
    logic              scan_match;
    logic [7:0]        scan_age;
    logic [2:0]        victim;
    logic [7:0]        victim_base;
    logic [5:0]        fill_len;
    logic              wr_hit;
    logic [15:0]       rd_lin;
    logic              rd_slot_ok;
    logic              rd_ok;
    logic [7:0]        rd_addr;
    logic              unused_data_bits;

    assign fsm_state        = state;
    assign unused_data_bits = ^w_input_data[31:DATA_W];

    // Request decode: range check on the full 32-bit dims, and the states
    // in which a rearmed request is honoured (w_rx_done wins in FILL).
    always_comb begin
        dims_ok    = (w_dim_m >= 32'd1) && (w_dim_m <= 32'd5) &&
                     (w_dim_n >= 32'd1) && (w_dim_n <= 32'd5);
        req_take   = w_en_input && w_dims_valid && armed;
        req_window = (state == ST_IDLE) || ((state == ST_FILL) && !w_rx_done);
        start_scan = req_take && req_window && dims_ok;
        req_err    = req_take && req_window && !dims_ok;
        do_grant   = w_en_input && (state == ST_GRANT);
        do_commit  = w_en_input && (state == ST_FILL) && pending &&
                     (w_rx_done || req_take);
    end

    // Examine the slot addressed by the scan counter; age is modulo 256.
    always_comb begin
        scan_valid = w_slot_valid[scan_idx];
        scan_age   = seq_ctr - tbl_seq[scan_idx];
        scan_match = scan_valid && (tbl_m[scan_idx] == cur_m) &&
                     (tbl_n[scan_idx] == cur_n);
    end

    // Victim choice from the finished scan, and the window it will own.
    always_comb begin
        if (int'(match_cnt) >= MAX_PER_DIM) begin
            victim = match_slot;
        end else if (free_found) begin
            victim = free_slot;
        end else begin
            victim = all_slot;
        end
        victim_base = 8'(int'(victim) * SLOT_WORDS);
        fill_len    = {3'b000, cur_m} * {3'b000, cur_n};
    end

    // A write lands only inside the granted window while filling.
    always_comb begin
        wr_hit = w_input_we && w_en_input && (state == ST_FILL) &&
                 ({1'b0, w_real_addr} >= {1'b0, w_base_addr}) &&
                 ({1'b0, w_real_addr} < fill_end);
    end

    // Read address decode; slots beyond the table read as zero.
    always_comb begin
        rd_lin     = 16'(w_rd_slot) * 16'(SLOT_WORDS) + 16'(w_rd_idx);
        rd_slot_ok = 32'(w_rd_slot) < NUM_SLOTS;
        rd_ok      = rd_slot_ok && (rd_lin < 16'(DEPTH));
        rd_addr    = rd_lin[7:0];
        w_rd_m     = 3'd0;
        w_rd_n     = 3'd0;
        if (rd_slot_ok) begin
            w_rd_m = tbl_m[w_rd_slot];
            w_rd_n = tbl_n[w_rd_slot];
        end
    end

    // FSM: IDLE -> SCAN (NUM_SLOTS cycles) -> GRANT -> FILL; enable low aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (!w_en_input) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_scan) begin
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (scan_idx == 3'(NUM_SLOTS - 1)) begin
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    state <= ST_FILL;
                end
                ST_FILL: begin
                    if (w_rx_done) begin
                        state <= ST_IDLE;
                    end else if (req_take) begin
                        state <= dims_ok ? ST_SCAN : ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Rearm, pending flag, latched dims and the committed-slot bitmap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed        <= 1'b1;
            pending      <= 1'b0;
            cur_m        <= 3'd0;
            cur_n        <= 3'd0;
            w_slot_valid <= '0;
        end else begin
            if (do_grant || req_err) begin
                armed <= 1'b0;
            end else if (!w_dims_valid) begin
                armed <= 1'b1;
            end

            if (!w_en_input || do_commit) begin
                pending <= 1'b0;
            end else if (do_grant) begin
                pending <= 1'b1;
            end

            if (start_scan) begin
                cur_m <= w_dim_m[2:0];
                cur_n <= w_dim_n[2:0];
            end

            if (do_grant) begin
                w_slot_valid[victim] <= 1'b0;
            end else if (do_commit) begin
                w_slot_valid[w_cur_slot] <= 1'b1;
            end
        end
    end

    // Scan trackers: lowest free, matching count/oldest, oldest overall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx   <= 3'd0;
            free_found <= 1'b0;
            free_slot  <= 3'd0;
            match_cnt  <= 4'd0;
            match_slot <= 3'd0;
            match_age  <= 8'd0;
            all_found  <= 1'b0;
            all_slot   <= 3'd0;
            all_age    <= 8'd0;
        end else if (start_scan) begin
            scan_idx   <= 3'd0;
            free_found <= 1'b0;
            match_cnt  <= 4'd0;
            all_found  <= 1'b0;
        end else if (w_en_input && (state == ST_SCAN)) begin
            scan_idx <= scan_idx + 3'd1;
            if (!scan_valid && !free_found) begin
                free_found <= 1'b1;
                free_slot  <= scan_idx;
            end
            if (scan_match) begin
                match_cnt <= match_cnt + 4'd1;
                if ((match_cnt == 4'd0) || (scan_age > match_age)) begin
                    match_slot <= scan_idx;
                    match_age  <= scan_age;
                end
            end
            if (scan_valid && (!all_found || (scan_age > all_age))) begin
                all_found <= 1'b1;
                all_slot  <= scan_idx;
                all_age   <= scan_age;
            end
        end
    end

    // Slot table update and sequence stamping at grant time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                tbl_m[i]   <= 3'd0;
                tbl_n[i]   <= 3'd0;
                tbl_seq[i] <= 8'd0;
            end
            seq_ctr <= 8'd0;
        end else if (do_grant) begin
            tbl_m[victim]   <= cur_m;
            tbl_n[victim]   <= cur_n;
            tbl_seq[victim] <= seq_ctr;
            seq_ctr         <= seq_ctr + 8'd1;
        end
    end

    // Grant outputs and the one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_base_addr  <= 8'd0;
            w_cur_slot   <= 3'd0;
            fill_end     <= 9'd0;
            w_addr_ready <= 1'b0;
            w_alloc_err  <= 1'b0;
            w_wr_drop    <= 1'b0;
        end else begin
            w_addr_ready <= do_grant;
            w_alloc_err  <= req_err;
            w_wr_drop    <= w_input_we && !wr_hit;
            if (do_grant) begin
                w_base_addr <= victim_base;
                w_cur_slot  <= victim;
                fill_end    <= {1'b0, victim_base} + {3'b000, fill_len};
            end
        end
    end

    // Element RAM write port.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            mem[w_real_addr] <= w_input_data[DATA_W-1:0];
        end
    end

    // Registered read port; a same-cycle write is seen on the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_rd_data <= '0;
        end else begin
            w_rd_data <= rd_ok ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_matrix_slot_allocator.sv
// Directed bench for matrix_slot_allocator: allocation, fill window,
// commit/replacement, rearm, abort and reset behaviour.
module tb_matrix_slot_allocator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        w_en_input;
    logic        w_dims_valid;
    logic [31:0] w_dim_m;
    logic [31:0] w_dim_n;
    logic        w_input_we;
    logic [7:0]  w_real_addr;
    logic [31:0] w_input_data;
    logic        w_rx_done;
    logic [7:0]  w_base_addr;
    logic        w_addr_ready;
    logic        w_alloc_err;
    logic        w_wr_drop;
    logic [7:0]  w_slot_valid;
    logic [2:0]  w_cur_slot;
    logic [2:0]  w_rd_slot;
    logic [4:0]  w_rd_idx;
    logic [3:0]  w_rd_data;
    logic [2:0]  w_rd_m;
    logic [2:0]  w_rd_n;
    logic [1:0]  fsm_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    matrix_slot_allocator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_en_input   (w_en_input),
        .w_dims_valid (w_dims_valid),
        .w_dim_m      (w_dim_m),
        .w_dim_n      (w_dim_n),
        .w_input_we   (w_input_we),
        .w_real_addr  (w_real_addr),
        .w_input_data (w_input_data),
        .w_rx_done    (w_rx_done),
        .w_base_addr  (w_base_addr),
        .w_addr_ready (w_addr_ready),
        .w_alloc_err  (w_alloc_err),
        .w_wr_drop    (w_wr_drop),
        .w_slot_valid (w_slot_valid),
        .w_cur_slot   (w_cur_slot),
        .w_rd_slot    (w_rd_slot),
        .w_rd_idx     (w_rd_idx),
        .w_rd_data    (w_rd_data),
        .w_rd_m       (w_rd_m),
        .w_rd_n       (w_rd_n),
        .fsm_state    (fsm_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"}, 32'(fsm_state), 32'd0);
        check({tag, "_valid"}, 32'(w_slot_valid), 32'd0);
        check({tag, "_base"}, 32'(w_base_addr), 32'd0);
        check({tag, "_cur"}, 32'(w_cur_slot), 32'd0);
        check({tag, "_ready"}, 32'(w_addr_ready), 32'd0);
        check({tag, "_err"}, 32'(w_alloc_err), 32'd0);
        check({tag, "_drop"}, 32'(w_wr_drop), 32'd0);
        check({tag, "_rd_data"}, 32'(w_rd_data), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        check_reset(tag);
        tick();
        rst_n = 1'b1;
    endtask

    // Raise the request and count edges until the grant pulse (bounded).
    task automatic request(input logic [31:0] m, input logic [31:0] n, output int lat);
        w_dim_m = m;
        w_dim_n = n;
        w_dims_valid = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!w_addr_ready && lat < 40);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data, output logic drop);
        w_input_we = 1'b1;
        w_real_addr = addr;
        w_input_data = data;
        tick();
        drop = w_wr_drop;
        w_input_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] slot, input logic [4:0] idx, output logic [3:0] data);
        w_rd_slot = slot;
        w_rd_idx = idx;
        tick();
        data = w_rd_data;
    endtask

    task automatic done();
        w_rx_done = 1'b1;
        tick();
        w_rx_done = 1'b0;
    endtask

    initial begin
        int lat;
        logic drop;
        logic [3:0] d;
        logic seen;

        rst_n = 1'b0;
        w_en_input = 1'b1;
        w_dims_valid = 1'b0;
        w_dim_m = 32'd0;
        w_dim_n = 32'd0;
        w_input_we = 1'b0;
        w_real_addr = 8'd0;
        w_input_data = 32'd0;
        w_rx_done = 1'b0;
        w_rd_slot = 3'd0;
        w_rd_idx = 5'd0;

        do_reset("rst0");

        // Seed address 6 with a 5x5 fill so a later dropped write is visible.
        request(32'd5, 32'd5, lat);
        w_dims_valid = 1'b0;
        check("seed_base", 32'(w_base_addr), 32'd0);
        wr(8'd6, 32'hC, drop);
        check("seed_drop", 32'(drop), 32'd0);
        done();
        do_reset("rst1");

        // 2x3 basic allocation, fill, window edge and read back.
        request(32'd2, 32'd3, lat);
        w_dims_valid = 1'b0;
        check("s1_latency", 32'(lat), 32'd10);
        check("s1_base", 32'(w_base_addr), 32'd0);
        check("s1_cur", 32'(w_cur_slot), 32'd0);
        for (int i = 0; i < 6; i++) begin
            wr(8'(i), 32'(i + 1) | 32'hA0, drop);
            check("s1_wr_drop", 32'(drop), 32'd0);
            if (i == 0) check("s1_ready_pulse", 32'(w_addr_ready), 32'd0);
        end
        wr(8'd6, 32'hF, drop);
        check("s1_edge_drop", 32'(drop), 32'd1);
        check("s1_valid_fill", 32'(w_slot_valid), 32'h00);
        done();
        check("s1_valid", 32'(w_slot_valid), 32'h01);
        check("s1_idle", 32'(fsm_state), 32'd0);
        wr(8'd3, 32'h9, drop);
        check("s1_idle_drop", 32'(drop), 32'd1);
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i + 1));
        exp_q.push_back(32'hC);
        for (int i = 0; i < 7; i++) begin
            rd(3'd0, 5'(i), d);
            check("s1_rd", 32'(d), exp_q.pop_front());
        end
        check("s1_rd_m", 32'(w_rd_m), 32'd2);
        check("s1_rd_n", 32'(w_rd_n), 32'd3);

        // 3x3 three times: third grant replaces the oldest match (slot 0).
        do_reset("rst2");
        request(32'd3, 32'd3, lat);
        w_dims_valid = 1'b0;
        check("s2_g1_base", 32'(w_base_addr), 32'd0);
        wr(8'd0, 32'h3, drop);
        done();
        check("s2_g1_valid", 32'(w_slot_valid), 32'h01);
        request(32'd3, 32'd3, lat);
        w_dims_valid = 1'b0;
        check("s2_g2_base", 32'(w_base_addr), 32'd25);
        check("s2_g2_cur", 32'(w_cur_slot), 32'd1);
        wr(8'd25, 32'h5, drop);
        done();
        check("s2_g2_valid", 32'(w_slot_valid), 32'h03);
        request(32'd3, 32'd3, lat);
        w_dims_valid = 1'b0;
        check("s2_g3_base", 32'(w_base_addr), 32'd0);
        check("s2_g3_cur", 32'(w_cur_slot), 32'd0);
        check("s2_g3_valid_fill", 32'(w_slot_valid), 32'h02);
        w_rd_slot = 3'd0;
        w_rd_idx = 5'd0;
        wr(8'd0, 32'h8, drop);
        check("s2_rw_old", 32'(w_rd_data), 32'h3);
        rd(3'd0, 5'd0, d);
        check("s2_rw_new", 32'(d), 32'h8);
        done();
        check("s2_g3_valid", 32'(w_slot_valid), 32'h03);
        rd(3'd1, 5'd0, d);
        check("s2_rd_slot1", 32'(d), 32'h5);
        check("s2_rd_m", 32'(w_rd_m), 32'd3);

        // Range errors, then a normal grant and the rearm rule.
        do_reset("rst3");
        w_dim_m = 32'd7;
        w_dim_n = 32'd1;
        w_dims_valid = 1'b1;
        tick();
        w_dims_valid = 1'b0;
        check("s3_err", 32'(w_alloc_err), 32'd1);
        check("s3_err_idle", 32'(fsm_state), 32'd0);
        tick();
        check("s3_err_pulse", 32'(w_alloc_err), 32'd0);
        w_dim_m = 32'd2;
        w_dim_n = 32'h1000_0003;
        w_dims_valid = 1'b1;
        tick();
        w_dims_valid = 1'b0;
        check("s3_err_wide", 32'(w_alloc_err), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | w_addr_ready;
        end
        check("s3_no_grant", 32'(seen), 32'd0);
        request(32'd1, 32'd1, lat);
        check("s3_latency", 32'(lat), 32'd10);
        check("s3_base", 32'(w_base_addr), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | w_addr_ready;
        end
        check("s3_hold_no_regrant", 32'(seen), 32'd0);
        check("s3_hold_fill", 32'(fsm_state), 32'd3);
        wr(8'd0, 32'hE, drop);
        check("s3_wr_drop", 32'(drop), 32'd0);
        w_dims_valid = 1'b0;
        tick();
        request(32'd2, 32'd2, lat);
        w_dims_valid = 1'b0;
        check("s3_g2_latency", 32'(lat), 32'd10);
        check("s3_g2_base", 32'(w_base_addr), 32'd25);
        check("s3_g2_cur", 32'(w_cur_slot), 32'd1);
        check("s3_g2_valid", 32'(w_slot_valid), 32'h01);
        done();
        check("s3_valid", 32'(w_slot_valid), 32'h03);
        rd(3'd0, 5'd0, d);
        check("s3_rd", 32'(d), 32'hE);

        // Enable drop mid-FILL: no commit, victim stays invalid.
        request(32'd4, 32'd1, lat);
        w_dims_valid = 1'b0;
        check("s4_base", 32'(w_base_addr), 32'd50);
        wr(8'd50, 32'h1, drop);
        check("s4_wr_drop", 32'(drop), 32'd0);
        w_en_input = 1'b0;
        tick();
        w_en_input = 1'b1;
        check("s4_abort_idle", 32'(fsm_state), 32'd0);
        check("s4_abort_valid", 32'(w_slot_valid), 32'h03);
        done();
        check("s4_late_done", 32'(w_slot_valid), 32'h03);
        wr(8'd50, 32'h2, drop);
        check("s4_after_abort_drop", 32'(drop), 32'd1);
        w_rd_slot = 3'd2;
        #1;
        check("s4_rd_m", 32'(w_rd_m), 32'd4);
        check("s4_rd_n", 32'(w_rd_n), 32'd1);

        // Reset in the middle of SCAN.
        w_dim_m = 32'd2;
        w_dim_n = 32'd2;
        w_dims_valid = 1'b1;
        tick();
        tick();
        tick();
        check("s5_in_scan", 32'(fsm_state), 32'd1);
        w_dims_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check_reset("s5_rst");
        check("s5_tbl_cleared", 32'(w_rd_m), 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | w_addr_ready;
        end
        check("s5_no_grant", 32'(seen), 32'd0);
        check("s5_valid", 32'(w_slot_valid), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
